// File: rtl/mdu_ctrl_if.sv
// E-stage multiply/divide request bundle and the HI/LO read/status signals
// returned to the pipeline.
interface mdu_ctrl_if;
    logic [3:0]  e_mdop;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_md;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output e_mdop, e_valid, e_rs, e_rt, d_is_md,
        input  busy, start, stall_md, hi, lo, md_rdata
    );

    modport slave (
        input  e_mdop, e_valid, e_rs, e_rt, d_is_md,
        output busy, start, stall_md, hi, lo, md_rdata
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer: owns HI/LO, models fixed latency
// with a down-counter and requests D-stage stalls for dependent MD ops.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] C_MULT_LD = MULT_CYCLES[3:0];
    localparam logic [3:0] C_DIV_LD  = DIV_CYCLES[3:0];

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic        r_pend_we;
    logic        w_busy, w_start, w_commit, w_is_arith, w_is_div, w_rt_zero;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_rs_mag, w_rt_mag, w_den_s, w_den_u;
    logic [31:0] w_quo_mag, w_rem_mag, w_squo, w_srem, w_uquo, w_urem;
    logic [31:0] w_res_hi, w_res_lo, w_rdata;
    logic        w_res_we;

    assign w_busy     = (r_state == S_RUN);
    assign w_is_arith = (bus.e_mdop >= OP_MULT) && (bus.e_mdop <= OP_DIVU);
    assign w_is_div   = (bus.e_mdop == OP_DIV) || (bus.e_mdop == OP_DIVU);
    assign w_start    = bus.e_valid & w_is_arith & ~w_busy;
    assign w_rt_zero  = (bus.e_rt == 32'd0);

    assign w_prod_s = {{32{bus.e_rs[31]}}, bus.e_rs} * {{32{bus.e_rt[31]}}, bus.e_rt};
    assign w_prod_u = {32'd0, bus.e_rs} * {32'd0, bus.e_rt};

    // Signed divide on magnitudes; a zero divisor is swapped for 1 so the
    // dividers never see it (the result is discarded anyway).
    assign w_rs_mag  = abs32(bus.e_rs);
    assign w_rt_mag  = abs32(bus.e_rt);
    assign w_den_s   = w_rt_zero ? 32'd1 : w_rt_mag;
    assign w_den_u   = w_rt_zero ? 32'd1 : bus.e_rt;
    assign w_quo_mag = w_rs_mag / w_den_s;
    assign w_rem_mag = w_rs_mag % w_den_s;
    assign w_squo    = (bus.e_rs[31] ^ bus.e_rt[31]) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_srem    = bus.e_rs[31] ? (32'd0 - w_rem_mag) : w_rem_mag;
    assign w_uquo    = bus.e_rs / w_den_u;
    assign w_urem    = bus.e_rs % w_den_u;

    // Result selection for the op being started this cycle.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b1;
        case (bus.e_mdop)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                w_res_hi = w_srem;
                w_res_lo = w_squo;
                w_res_we = ~w_rt_zero;
            end
            OP_DIVU: begin
                w_res_hi = w_urem;
                w_res_lo = w_uquo;
                w_res_we = ~w_rt_zero;
            end
            default: w_res_we = 1'b1;
        endcase
    end

    // Next-state and latency counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_div ? C_DIV_LD : C_MULT_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pending result captured at start, held until the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= w_res_we;
        end
    end

    // HI/LO: completion write or direct mthi/mtlo while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (bus.e_valid && !w_busy && bus.e_mdop == OP_MTHI) begin
            r_hi <= bus.e_rs;
        end else if (bus.e_valid && !w_busy && bus.e_mdop == OP_MTLO) begin
            r_lo <= bus.e_rs;
        end
    end

    // Move-from read mux.
    always_comb begin
        w_rdata = 32'd0;
        case (bus.e_mdop)
            OP_MFHI: w_rdata = r_hi;
            OP_MFLO: w_rdata = r_lo;
            default: w_rdata = 32'd0;
        endcase
    end

    assign bus.busy     = w_busy;
    assign bus.start    = w_start;
    assign bus.stall_md = bus.d_is_md & (w_start | w_busy);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.md_rdata = w_rdata;
endmodule
